sccb_clk_phase_gen: RTL and testbench



---
 rtl/sccb_pkg.sv | 17 +
 rtl/sccb_sync_2ff.sv | 26 ++
 rtl/sccb_clk_phase_gen.sv | 101 ++++++++++
 tb/tb_sccb_clk_phase_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared constants and helpers for the SCCB SIO_C timing generator.
package sccb_pkg;

  localparam int unsigned SCCB_CNT_W = 16;

  typedef enum logic {
    PHASE_LOW  = 1'b0,
    PHASE_HIGH = 1'b1
  } phase_e;

  // Shortest legal SIO_C half period, in clk cycles, for a given clock/bus rate pair.
  function automatic int unsigned min_hcyc(input int unsigned clk_freq,
                                           input int unsigned max_sccb_freq);
    return clk_freq / (max_sccb_freq * 2);
  endfunction

endpackage

// File: rtl/sccb_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; resets to all ones (bus idle high).
module sccb_sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/sccb_clk_phase_gen.sv
// SIO_C half-period timer and strobe generator for the SCCB master.
// Optional clock stretching by the slave is enabled with the SCCB_STRETCH_EN macro.
module sccb_clk_phase_gen
  import sccb_pkg::*;
#(
  parameter int unsigned INTERNAL_CLK_FREQ = 125_000_000,
  parameter int unsigned MAX_SCCB_FREQ     = 100_000,
  parameter int unsigned CNT_W             = SCCB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cntr_en_i,
  input  logic [CNT_W-1:0] hcyc_len_i,
`ifdef SCCB_STRETCH_EN
  input  logic             sio_c_i,
`endif
  output logic             phase_o,
  output logic             sio_c_tgl_en_o,
  output logic             tick_setup_o,
  output logic             tick_sample_o,
  output logic             cycle_done_o,
  output logic [CNT_W-1:0] hcyc_eff_o,
  output logic             stretch_o
);

  localparam logic [CNT_W-1:0] MIN_HCYC = CNT_W'(min_hcyc(INTERNAL_CLK_FREQ, MAX_SCCB_FREQ));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcyc_q;
  phase_e           phase;

  logic [CNT_W-1:0] hcyc_eff;
  logic [CNT_W-1:0] mid;
  logic             run;
  logic             at_last;
  logic             at_mid;
  logic             hold;
  logic             tgl;

  assign hcyc_eff = (hcyc_len_i < MIN_HCYC) ? MIN_HCYC : hcyc_len_i;
  assign mid      = hcyc_q >> 1;
  assign run      = cntr_en_i;
  assign at_last  = (cnt == (hcyc_q - CNT_ONE));
  assign at_mid   = (cnt == mid);

`ifdef SCCB_STRETCH_EN
  logic sio_c_sync;

  sccb_sync_2ff #(
    .W (1)
  ) u_sio_c_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sio_c_i),
    .q     (sio_c_sync)
  );

  // The slave can only hold SIO_C low during the high half; the pad lags the
  // rising toggle by the synchroniser depth, so cnt==0 of the high half is held too.
  assign hold = (phase == PHASE_HIGH) && !sio_c_sync;
`else
  assign hold = 1'b0;
`endif

  assign tgl = run && at_last && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      phase  <= PHASE_LOW;
      hcyc_q <= MIN_HCYC;
    end else if (!run) begin
      cnt    <= '0;
      phase  <= PHASE_LOW;
      hcyc_q <= hcyc_eff;
    end else if (hold) begin
      cnt <= cnt;
    end else if (at_last) begin
      cnt <= '0;
      if (phase == PHASE_HIGH) begin
        phase  <= PHASE_LOW;
        // New length only lands on a full-cycle boundary so SIO_C never glitches.
        hcyc_q <= hcyc_eff;
      end else begin
        phase <= PHASE_HIGH;
      end
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign phase_o        = (phase == PHASE_HIGH);
  assign sio_c_tgl_en_o = tgl;
  assign tick_setup_o   = run && (phase == PHASE_LOW) && at_mid;
  assign tick_sample_o  = run && (phase == PHASE_HIGH) && at_mid && !hold;
  assign cycle_done_o   = tgl && (phase == PHASE_HIGH);
  assign hcyc_eff_o     = hcyc_q;
  assign stretch_o      = run && hold;

endmodule

// File: tb/tb_sccb_clk_phase_gen.sv
// Directed bench for sccb_clk_phase_gen; define SCCB_STRETCH_EN to also cover clock stretching.
module tb_sccb_clk_phase_gen;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cntr_en = 1'b0;
  logic [CNT_W-1:0] hcyc_len = '0;
  logic             phase_o;
  logic             sio_c_tgl_en_o;
  logic             tick_setup_o;
  logic             tick_sample_o;
  logic             cycle_done_o;
  logic [CNT_W-1:0] hcyc_eff_o;
  logic             stretch_o;
`ifdef SCCB_STRETCH_EN
  logic             sio_c_i = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int shown    = 0;

  always #5 clk = ~clk;

  sccb_clk_phase_gen #(
    .INTERNAL_CLK_FREQ (125_000_000),
    .MAX_SCCB_FREQ     (100_000),
    .CNT_W             (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cntr_en_i      (cntr_en),
    .hcyc_len_i     (hcyc_len),
`ifdef SCCB_STRETCH_EN
    .sio_c_i        (sio_c_i),
`endif
    .phase_o        (phase_o),
    .sio_c_tgl_en_o (sio_c_tgl_en_o),
    .tick_setup_o   (tick_setup_o),
    .tick_sample_o  (tick_sample_o),
    .cycle_done_o   (cycle_done_o),
    .hcyc_eff_o     (hcyc_eff_o),
    .stretch_o      (stretch_o)
  );

  // Expected {phase, tgl, setup, sample, done} at position p of a 2*h-cycle SIO_C period.
  function automatic logic [4:0] exp_vec(input int p, input int h);
    logic ph;
    int   c;
    int   m;
    m  = h / 2;
    ph = (p >= h);
    c  = ph ? p - h : p;
    return {ph, c == h - 1, !ph && c == m, ph && c == m, ph && c == h - 1};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    cntr_en  = 1'b1;
    hcyc_len = 16'd1000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, stretch_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, stretch_o});
    end
    n_checks++;
    if (hcyc_eff_o !== 16'd625) begin
      n_fail++;
      $display("FAIL reset_hcyc_eff: got %0d expected 625", hcyc_eff_o);
    end
    cntr_en = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (hcyc_eff_o !== 16'd1000) begin
      n_fail++;
      $display("FAIL idle_load: got %0d expected 1000", hcyc_eff_o);
    end
    next_cycle();
    hcyc_len = 16'd0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (hcyc_eff_o !== 16'd625) begin
      n_fail++;
      $display("FAIL zero_clamp: got %0d expected 625", hcyc_eff_o);
    end
    next_cycle();
  endtask

  task automatic test_nominal();
    logic [4:0] exp;
    hcyc_len = 16'd1000;
    next_cycle();
    cntr_en = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      exp = exp_vec(k % 2000, 1000);
      @(negedge clk);
      n_checks++;
      if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, hcyc_eff_o} !== {exp, 16'd1000}) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL nominal k=%0d: got %b/%0d expected %b/1000", k,
                   {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o}, hcyc_eff_o, exp);
      end
      next_cycle();
    end
    cntr_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_clamp();
    logic [4:0] exp;
    hcyc_len = 16'd100;
    next_cycle();
    cntr_en = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      exp = exp_vec(k % 1250, 625);
      @(negedge clk);
      n_checks++;
      if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, hcyc_eff_o} !== {exp, 16'd625}) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL clamp k=%0d: got %b/%0d expected %b/625", k,
                   {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o}, hcyc_eff_o, exp);
      end
      next_cycle();
    end
    cntr_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_len_change();
    logic [4:0]       exp;
    logic [CNT_W-1:0] exp_eff;
    hcyc_len = 16'd1000;
    next_cycle();
    cntr_en = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if (k == 300) hcyc_len = 16'd2000;
      if (k < 2000) begin
        exp     = exp_vec(k, 1000);
        exp_eff = 16'd1000;
      end else begin
        exp     = exp_vec((k - 2000) % 4000, 2000);
        exp_eff = 16'd2000;
      end
      @(negedge clk);
      n_checks++;
      if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, hcyc_eff_o} !== {exp, exp_eff}) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL len_change k=%0d: got %b/%0d expected %b/%0d", k,
                   {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o}, hcyc_eff_o, exp, exp_eff);
      end
      next_cycle();
    end
    cntr_en  = 1'b0;
    hcyc_len = 16'd1000;
    next_cycle();
  endtask

  task automatic test_disable_mid_high();
    logic [4:0] exp;
    next_cycle();
    cntr_en = 1'b1;
    for (int k = 0; k < 3410; k++) begin
      cntr_en = !(k >= 1400 && k < 1410);
      if (k < 1400)      exp = exp_vec(k, 1000);
      else if (k < 1410) exp = {k == 1400, 4'b0000};
      else               exp = exp_vec(k - 1410, 1000);
      @(negedge clk);
      n_checks++;
      if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o} !== exp) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL disable k=%0d: got %b expected %b", k,
                   {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o}, exp);
      end
      next_cycle();
    end
    cntr_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_disable_on_toggle();
    logic [4:0] exp;
    cntr_en = 1'b1;
    for (int k = 0; k < 2001; k++) begin
      cntr_en = !(k == 999 || k == 1000);
      if (k < 999)       exp = exp_vec(k, 1000);
      else if (k < 1001) exp = 5'b00000;
      else               exp = exp_vec(k - 1001, 1000);
      @(negedge clk);
      n_checks++;
      if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o} !== exp) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL disable_on_toggle k=%0d: got %b expected %b", k,
                   {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o}, exp);
      end
      next_cycle();
    end
    cntr_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_midrun();
    cntr_en = 1'b1;
    repeat (1200) next_cycle();
    @(negedge clk);
    n_checks++;
    if (phase_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_phase: got %b expected 1", phase_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, stretch_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: got %b expected 000000",
               {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, stretch_o});
    end
    n_checks++;
    if (hcyc_eff_o !== 16'd625) begin
      n_fail++;
      $display("FAIL midrun_reset_hcyc_eff: got %0d expected 625", hcyc_eff_o);
    end
    cntr_en = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

`ifdef SCCB_STRETCH_EN
  task automatic test_stretch();
    logic [5:0] exp;
    hcyc_len = 16'd1000;
    next_cycle();
    cntr_en = 1'b1;
    for (int k = 0; k < 2053; k++) begin
      sio_c_i = (k >= 1050);
      exp = {k >= 1000 && k <= 2051, k == 999 || k == 2051, k == 500, k == 1552, k == 2051,
             k >= 1000 && k <= 1051};
      @(negedge clk);
      n_checks++;
      if ({phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, stretch_o} !== exp) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL stretch k=%0d: got %b expected %b", k,
                   {phase_o, sio_c_tgl_en_o, tick_setup_o, tick_sample_o, cycle_done_o, stretch_o}, exp);
      end
      next_cycle();
    end
    cntr_en = 1'b0;
    sio_c_i = 1'b1;
    next_cycle();
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_len_change();
    test_disable_mid_high();
    test_disable_on_toggle();
    test_reset_midrun();
`ifdef SCCB_STRETCH_EN
    test_stretch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
